pipeline_stage_reg: RTL and testbench



---
 rtl/pipeline_stage_reg_pkg.sv | 19 +
 rtl/pipeline_stage_reg_entry.sv | 34 +++
 rtl/pipeline_stage_reg.sv | 94 +++++++++
 tb/tb_pipeline_stage_reg.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_reg_pkg.sv
// Shared pipeline definitions: per-stage bundle widths and the stage-register
// occupancy encoding, which doubles as the entry count.
package pipeline_stage_reg_pkg;

  localparam int IF_CTRL_W  = 2;
  localparam int IF_DATA_W  = 96;
  localparam int ID_CTRL_W  = 14;
  localparam int ID_DATA_W  = 165;
  localparam int EM_CTRL_W  = 10;
  localparam int EM_DATA_W  = 133;
  localparam int MW_CTRL_W  = 5;
  localparam int MW_DATA_W  = 101;

  typedef logic [1:0] state_t;
  localparam state_t S_EMPTY = 2'd0;
  localparam state_t S_ONE   = 2'd1;
  localparam state_t S_TWO   = 2'd2;

endpackage

// File: rtl/pipeline_stage_reg_entry.sv
// One held pipeline entry {valid, ctrl, data}. Clear drops valid and control
// but keeps the payload, so a bubble never carries live write enables.
module pipe_entry_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 133
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (ld) begin
      q_valid <= d_valid;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Inter-stage register with valid/ready handshake, optional two-entry skid
// (registered in_ready), flush, and control zeroing on bubbles.
module pipeline_stage_reg
  import pipeline_stage_reg_pkg::*;
#(
  parameter int CTRL_W = EM_CTRL_W,
  parameter int DATA_W = EM_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  state_t state, nxt;
  logic acc, rel, ld_in, mv_skid;
  logic sk_valid;
  logic [CTRL_W-1:0] sk_ctrl;
  logic [DATA_W-1:0] sk_data;

  assign acc = in_valid && in_ready;
  assign rel = out_valid && out_ready;
  assign ld_in   = acc && (state == S_EMPTY || rel);
  assign mv_skid = (state == S_TWO) && rel;

  always_comb begin
    nxt = state;
    if (flush) nxt = S_EMPTY;
    else begin
      case (state)
        S_EMPTY: if (acc) nxt = S_ONE;
        S_ONE: begin
          if (acc && !rel)      nxt = SKID ? S_TWO : S_ONE;
          else if (rel && !acc) nxt = S_EMPTY;
        end
        S_TWO:   if (rel) nxt = S_ONE;
        default: nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_EMPTY;
    else      state <= nxt;
  end

  assign count = state;

  // Main drives the outputs; clearing on next==EMPTY covers flush and bubbles.
  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk(clk), .rst(rst),
    .ld(ld_in || mv_skid), .clr(nxt == S_EMPTY),
    .d_valid(mv_skid ? sk_valid : 1'b1),
    .d_ctrl(mv_skid ? sk_ctrl : in_ctrl),
    .d_data(mv_skid ? sk_data : in_data),
    .q_valid(out_valid), .q_ctrl(out_ctrl), .q_data(out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic rdy_r;
      logic sk_ld;
      assign sk_ld = (state == S_ONE) && acc && !rel;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk(clk), .rst(rst),
        .ld(sk_ld), .clr(flush || mv_skid),
        .d_valid(1'b1), .d_ctrl(in_ctrl), .d_data(in_data),
        .q_valid(sk_valid), .q_ctrl(sk_ctrl), .q_data(sk_data)
      );

      always_ff @(posedge clk) begin
        if (!rst) rdy_r <= 1'b1;
        else      rdy_r <= (nxt != S_TWO);
      end
      assign in_ready = rdy_r;
    end else begin : g_noskid
      assign sk_valid = 1'b0;
      assign sk_ctrl  = '0;
      assign sk_data  = '0;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench: skid-mode and single-entry instances share the clock;
// checks are taken 1 time unit after each rising edge.
module tb_pipeline_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         fl1, iv1, ir1, ov1, or1;
  logic [9:0]   ic1, oc1;
  logic [132:0] id1, od1;
  logic [1:0]   cn1;

  logic         fl0, iv0, ir0, ov0, or0;
  logic [9:0]   ic0, oc0;
  logic [132:0] id0, od0;
  logic [1:0]   cn0;

  int checks = 0;
  int errors = 0;

  pipeline_stage_reg #(.CTRL_W(10), .DATA_W(133), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_ctrl(ic1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1), .count(cn1));

  pipeline_stage_reg #(.CTRL_W(10), .DATA_W(133), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_ctrl(ic0), .in_data(id0), .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0), .count(cn0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fl1 = 0; iv1 = 1; or1 = 0; ic1 = 10'h3FF; id1 = 133'h55;
    fl0 = 0; iv0 = 1; or0 = 0; ic0 = 10'h3FF; id0 = 133'h55;
    tick(); tick();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov1); end
    checks++; if (oc1 !== 10'h0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", oc1); end
    checks++; if (od1 !== 133'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", od1); end
    checks++; if (cn1 !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cn1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir1); end
    checks++; if (ov0 !== 1'b0 || cn0 !== 2'd0) begin errors++; $display("FAIL reset_skid0 got v=%b c=%0d exp 0/0", ov0, cn0); end
    iv1 = 0; iv0 = 0;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    or1 = 1;
    for (int i = 1; i <= 8; i++) begin
      iv1 = 1; id1 = 133'(i); ic1 = 10'(i);
      tick();
      checks++; if (ov1 !== 1'b1 || od1 !== 133'(i)) begin errors++; $display("FAIL stream_data[%0d] got v=%b d=%h exp 1/%h", i, ov1, od1, i); end
      checks++; if (cn1 !== 2'd1 || oc1 !== 10'(i)) begin errors++; $display("FAIL stream_count[%0d] got c=%0d ctrl=%h exp 1/%h", i, cn1, oc1, i); end
    end
    iv1 = 0;
    tick();
    checks++; if (ov1 !== 1'b0 || cn1 !== 2'd0 || oc1 !== 10'h0) begin errors++; $display("FAIL stream_drain got v=%b c=%0d ctrl=%h exp 0/0/0", ov1, cn1, oc1); end
  endtask

  task automatic test_backpressure();
    iv1 = 1; id1 = 133'hA; ic1 = 10'h00A; or1 = 0;
    tick();
    checks++; if (od1 !== 133'hA || cn1 !== 2'd1 || ir1 !== 1'b1) begin errors++; $display("FAIL bp_first got d=%h c=%0d r=%b exp A/1/1", od1, cn1, ir1); end
    id1 = 133'hB; ic1 = 10'h00B;
    tick();
    checks++; if (od1 !== 133'hA || cn1 !== 2'd2 || ir1 !== 1'b0) begin errors++; $display("FAIL bp_full got d=%h c=%0d r=%b exp A/2/0", od1, cn1, ir1); end
    id1 = 133'hC; ic1 = 10'h00C;
    tick();
    checks++; if (od1 !== 133'hA || cn1 !== 2'd2 || ir1 !== 1'b0) begin errors++; $display("FAIL bp_hold got d=%h c=%0d r=%b exp A/2/0", od1, cn1, ir1); end
    or1 = 1;
    tick();
    checks++; if (od1 !== 133'hB || oc1 !== 10'h00B || cn1 !== 2'd1 || ir1 !== 1'b1) begin errors++; $display("FAIL bp_skid_out got d=%h c=%0d r=%b exp B/1/1", od1, cn1, ir1); end
    tick();
    checks++; if (od1 !== 133'hC || ov1 !== 1'b1 || cn1 !== 2'd1) begin errors++; $display("FAIL bp_third got d=%h v=%b c=%0d exp C/1/1", od1, ov1, cn1); end
    iv1 = 0;
    tick();
    checks++; if (ov1 !== 1'b0 || cn1 !== 2'd0) begin errors++; $display("FAIL bp_drain got v=%b c=%0d exp 0/0", ov1, cn1); end
  endtask

  task automatic test_flush();
    iv1 = 1; id1 = 133'h1; ic1 = 10'h101; or1 = 0;
    tick();
    id1 = 133'h2; ic1 = 10'h102;
    tick();
    checks++; if (cn1 !== 2'd2) begin errors++; $display("FAIL flush_setup got c=%0d exp 2", cn1); end
    id1 = 133'hD; ic1 = 10'h10D; fl1 = 1;
    tick();
    checks++; if (cn1 !== 2'd0 || ov1 !== 1'b0 || oc1 !== 10'h0) begin errors++; $display("FAIL flush_clear got c=%0d v=%b ctrl=%h exp 0/0/0", cn1, ov1, oc1); end
    checks++; if (ir1 !== 1'b1 || od1 !== 133'h1) begin errors++; $display("FAIL flush_hold got r=%b d=%h exp 1/1", ir1, od1); end
    fl1 = 0; iv1 = 0; or1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ov1 !== 1'b0 || od1 === 133'hD) begin errors++; $display("FAIL flush_no_D[%0d] got v=%b d=%h exp 0/not D", i, ov1, od1); end
    end
  endtask

  task automatic test_bubble();
    or1 = 1; ic1 = 10'h3FF; id1 = 133'h77;
    iv1 = 1; tick();
    checks++; if (oc1 !== 10'h3FF) begin errors++; $display("FAIL bubble_0 got %h exp 3FF", oc1); end
    iv1 = 0; tick();
    checks++; if (oc1 !== 10'h000 || ov1 !== 1'b0) begin errors++; $display("FAIL bubble_1 got %h v=%b exp 000/0", oc1, ov1); end
    iv1 = 1; tick();
    checks++; if (oc1 !== 10'h3FF) begin errors++; $display("FAIL bubble_2 got %h exp 3FF", oc1); end
    iv1 = 0; tick();
  endtask

  task automatic test_skid0();
    iv0 = 1; id0 = 133'h21; ic0 = 10'h021; or0 = 0;
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL s0_empty_ready got %b exp 1", ir0); end
    tick();
    checks++; if (od0 !== 133'h21 || cn0 !== 2'd1) begin errors++; $display("FAIL s0_load got d=%h c=%0d exp 21/1", od0, cn0); end
    id0 = 133'h22; ic0 = 10'h022;
    #1;
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL s0_full_ready got %b exp 0", ir0); end
    tick();
    checks++; if (od0 !== 133'h21 || cn0 !== 2'd1) begin errors++; $display("FAIL s0_hold got d=%h c=%0d exp 21/1", od0, cn0); end
    or0 = 1;
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL s0_comb_ready got %b exp 1", ir0); end
    tick();
    checks++; if (od0 !== 133'h22 || oc0 !== 10'h022 || cn0 !== 2'd1) begin errors++; $display("FAIL s0_replace got d=%h c=%0d exp 22/1", od0, cn0); end
    iv0 = 0;
    tick();
    checks++; if (cn0 !== 2'd0 || oc0 !== 10'h0) begin errors++; $display("FAIL s0_drain got c=%0d ctrl=%h exp 0/0", cn0, oc0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_skid0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
